// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronizes the raw lines, deframes 11-bit frames,
// checks parity/stop and queues good scancodes in a FIFO for CPU reads.
module ps2_scancode_rx #(
  parameter int DEPTH          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        pop,
  output logic [31:0] rd_data,
  output logic        valid,
  output logic        full
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   prev_clk_q;
  logic                   s_clk;
  logic                   s_data;
  logic                   fall;

  state_t      state_q, state_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [TW-1:0] to_q, to_d;
  logic        push;
  logic        ferr_set;

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        ovf_q, ovf_d;
  logic        ferr_q, ferr_d;
  logic        empty;
  logic        do_push;
  logic        do_pop;
  logic [7:0]  head;

  assign s_clk  = clk_sync_q[SYNC_STAGES-1];
  assign s_data = data_sync_q[SYNC_STAGES-1];
  assign fall   = prev_clk_q & ~s_clk;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      prev_clk_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      prev_clk_q  <= s_clk;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    to_d     = (state_q == IDLE || fall) ? '0 : to_q + 1'b1;
    if (state_q != IDLE && !fall && to_q == TO_LAST) begin
      // Device stalled mid-frame: drop the partial byte and resync
      state_d  = IDLE;
      shift_d  = '0;
      bitcnt_d = '0;
      ferr_set = 1'b1;
      to_d     = '0;
    end else if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!s_data) begin
            state_d  = DATA;
            bitcnt_d = '0;
          end
        end
        DATA: begin
          shift_d  = {s_data, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = s_data;
          state_d = STOP;
        end
        STOP: begin
          if (s_data && ^{shift_q, par_q}) push = 1'b1;
          else ferr_set = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      to_q     <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      to_q     <= to_d;
    end
  end

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign valid   = ~empty;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];
  assign rd_data = {16'b0, valid, ovf_q, ferr_q, 5'b0, head};

  always_comb begin
    wptr_d = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = do_pop ? rptr_q + 1'b1 : rptr_q;
    ovf_d  = pop ? 1'b0 : ovf_q;
    ferr_d = pop ? 1'b0 : ferr_q;
    if (push && full && !do_pop) ovf_d = 1'b1;
    if (ferr_set) ferr_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      ferr_q <= ferr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= shift_q;
  end

endmodule
